// File: rtl/count_sequence_checker.sv
// rtl/count_sequence_checker.sv - modulo-N count sequence monitor with lock, wrap and error reporting
module count_sequence_checker #(
  parameter int MODULO     = 10,
  parameter int WIDTH      = 6,
  parameter int LOCK_COUNT = 3,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     count_i,
  input  logic                 valid_i,
  output logic                 locked_o,
  output logic                 wrap_o,
  output logic                 err_o,
  output logic [ERR_CNT_W-1:0] err_count_o,
  output logic [WIDTH-1:0]     expected_o
);

  localparam int MW = $clog2(LOCK_COUNT + 1);

  // Wide constants so MODULO == 2**WIDTH neither overflows nor truncates.
  localparam logic [WIDTH:0]  MOD_W  = (WIDTH + 1)'(MODULO);
  localparam logic [WIDTH:0]  MOD_M1 = (WIDTH + 1)'(MODULO - 1);
  localparam logic [MW-1:0]   LOCK_N = MW'(LOCK_COUNT);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // A single correct sample is enough to lock when LOCK_COUNT is 1.
  localparam state_t SEED_STATE = (LOCK_COUNT == 1) ? LOCKED : VERIFY;

  state_t                 state_q, state_d;
  logic [MW-1:0]          match_q, match_d;
  logic [WIDTH-1:0]       expected_q, expected_d;
  logic [ERR_CNT_W-1:0]   err_count_q, err_count_d;
  logic                   wrap_q, wrap_d;
  logic                   err_q, err_d;

  logic                   in_range;
  logic                   hit;
  logic [WIDTH-1:0]       count_next;
  logic [MW-1:0]          match_inc;

  function automatic logic [WIDTH-1:0] next_count(input logic [WIDTH-1:0] x);
    logic [WIDTH:0] x_ext;
    x_ext = {1'b0, x};
    if (x_ext == MOD_M1) begin
      return '0;
    end
    x_ext = x_ext + (WIDTH + 1)'(1);
    return x_ext[WIDTH-1:0];
  endfunction

  assign in_range   = ({1'b0, count_i} < MOD_W);
  assign hit        = (count_i == expected_q);
  assign count_next = next_count(count_i);
  assign match_inc  = match_q + MW'(1);

  // State register and registered outputs; reset wins over any valid sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HUNT;
      match_q     <= '0;
      expected_q  <= '0;
      err_count_q <= '0;
      wrap_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      match_q     <= match_d;
      expected_q  <= expected_d;
      err_count_q <= err_count_d;
      wrap_q      <= wrap_d;
      err_q       <= err_d;
    end
  end

  // Next-state: hunt for an in-range seed, verify the run, then police it while locked.
  always_comb begin
    state_d     = state_q;
    match_d     = match_q;
    expected_d  = expected_q;
    err_count_d = err_count_q;
    wrap_d      = 1'b0;
    err_d       = 1'b0;
    if (valid_i) begin
      unique case (state_q)
        HUNT: begin
          if (in_range) begin
            expected_d = count_next;
            match_d    = MW'(1);
            state_d    = SEED_STATE;
          end
        end
        VERIFY: begin
          if (hit) begin
            expected_d = count_next;
            match_d    = match_inc;
            if (match_inc == LOCK_N) begin
              state_d = LOCKED;
            end
          end else if (in_range) begin
            expected_d = count_next;
            match_d    = MW'(1);
          end else begin
            match_d = '0;
            state_d = HUNT;
          end
        end
        LOCKED: begin
          if (hit) begin
            expected_d = count_next;
            wrap_d     = (count_i == '0);
          end else begin
            err_d = 1'b1;
            if (err_count_q != '1) begin
              err_count_d = err_count_q + ERR_CNT_W'(1);
            end
            if (in_range) begin
              expected_d = count_next;
              match_d    = MW'(1);
              state_d    = SEED_STATE;
            end else begin
              match_d = '0;
              state_d = HUNT;
            end
          end
        end
        default: begin
          match_d = '0;
          state_d = HUNT;
        end
      endcase
    end
  end

  assign locked_o    = (state_q == LOCKED);
  assign wrap_o      = wrap_q;
  assign err_o       = err_q;
  assign err_count_o = err_count_q;
  assign expected_o  = expected_q;

endmodule

// File: tb/tb_count_sequence_checker.sv
// tb/tb_count_sequence_checker.sv - directed self-checking bench for count_sequence_checker
module tb_count_sequence_checker;

  logic       clk;
  logic       rst;
  logic [5:0] count_i;
  logic       valid_i;

  logic       locked_o, wrap_o, err_o;
  logic [7:0] err_count_o;
  logic [5:0] expected_o;

  logic       s_locked_o, s_wrap_o, s_err_o;
  logic [1:0] s_err_count_o;
  logic [5:0] s_expected_o;

  int compared = 0;
  int mismatched = 0;

  count_sequence_checker #(.MODULO(10), .WIDTH(6), .LOCK_COUNT(3), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .count_i(count_i), .valid_i(valid_i),
    .locked_o(locked_o), .wrap_o(wrap_o), .err_o(err_o),
    .err_count_o(err_count_o), .expected_o(expected_o)
  );

  count_sequence_checker #(.MODULO(10), .WIDTH(6), .LOCK_COUNT(3), .ERR_CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .count_i(count_i), .valid_i(valid_i),
    .locked_o(s_locked_o), .wrap_o(s_wrap_o), .err_o(s_err_o),
    .err_count_o(s_err_count_o), .expected_o(s_expected_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int nxt(input int x);
    return (x == 9) ? 0 : x + 1;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one input vector, let one edge pass, then check every main-DUT output.
  task automatic step(input logic v, input int c, input string tag,
                      input int el, input int ew, input int ee, input int ec, input int ex);
    valid_i = v;
    count_i = 6'(c);
    @(posedge clk);
    #1;
    chk({tag, ".locked"}, 32'(locked_o), el);
    chk({tag, ".wrap"}, 32'(wrap_o), ew);
    chk({tag, ".err"}, 32'(err_o), ee);
    chk({tag, ".err_count"}, 32'(err_count_o), ec);
    chk({tag, ".expected"}, 32'(expected_o), ex);
  endtask

  initial begin
    int e;
    int b;
    int s1;
    int s2;
    int sat;

    rst = 1'b1;
    valid_i = 1'b0;
    count_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.locked", 32'(locked_o), 0);
    chk("rst.expected", 32'(expected_o), 0);
    chk("rst.err_count", 32'(err_count_o), 0);
    rst = 1'b0;
    step(1'b0, 0, "idle0", 0, 0, 0, 0, 0);
    step(1'b0, 0, "idle1", 0, 0, 0, 0, 0);

    step(1'b1, 0, "lock0", 0, 0, 0, 0, 1);
    step(1'b1, 1, "lock1", 0, 0, 0, 0, 2);
    step(1'b1, 2, "lock2", 1, 0, 0, 0, 3);

    for (int c = 3; c <= 9; c++) step(1'b1, c, "run", 1, 0, 0, 0, nxt(c));
    step(1'b1, 0, "wrap0", 1, 1, 0, 0, 1);
    step(1'b1, 1, "post_wrap", 1, 0, 0, 0, 2);

    for (int c = 2; c <= 5; c++) step(1'b1, c, "to6", 1, 0, 0, 0, c + 1);
    step(1'b1, 6, "e6", 1, 0, 0, 0, 7);
    step(1'b1, 8, "skip8", 0, 0, 1, 1, 9);
    step(1'b1, 9, "rv9", 0, 0, 0, 1, 0);
    step(1'b1, 0, "relock0_nowrap", 1, 0, 0, 1, 1);

    step(1'b1, 5, "glitch5", 0, 0, 1, 2, 6);
    step(1'b1, 6, "rv6", 0, 0, 0, 2, 7);
    step(1'b1, 7, "rv7", 1, 0, 0, 2, 8);
    rst = 1'b1;
    step(1'b1, 8, "rst_locked", 0, 0, 0, 0, 0);
    rst = 1'b0;

    step(1'b1, 12, "oor12", 0, 0, 0, 0, 0);
    step(1'b1, 15, "oor15", 0, 0, 0, 0, 0);
    repeat (4) step(1'b0, 0, "gap_a", 0, 0, 0, 0, 0);
    step(1'b1, 4, "h4", 0, 0, 0, 0, 5);
    repeat (2) step(1'b0, 9, "gap_b", 0, 0, 0, 0, 5);
    step(1'b1, 5, "h5", 0, 0, 0, 0, 6);
    repeat (2) step(1'b0, 3, "gap_c", 0, 0, 0, 0, 6);
    step(1'b1, 6, "h6", 1, 0, 0, 0, 7);

    rst = 1'b1;
    step(1'b0, 0, "rst2", 0, 0, 0, 0, 0);
    rst = 1'b0;
    step(1'b1, 0, "sat_lock0", 0, 0, 0, 0, 1);
    step(1'b1, 1, "sat_lock1", 0, 0, 0, 0, 2);
    step(1'b1, 2, "sat_lock2", 1, 0, 0, 0, 3);
    e = 3;
    for (int g = 0; g < 5; g++) begin
      b = (e + 5) % 10;
      sat = (g + 1 > 3) ? 3 : g + 1;
      step(1'b1, b, "glitch", 0, 0, 1, g + 1, nxt(b));
      chk("sat.err", 32'(s_err_o), 1);
      chk("sat.err_count", 32'(s_err_count_o), sat);
      s1 = nxt(b);
      step(1'b1, s1, "glitch_rv", 0, 0, 0, g + 1, nxt(s1));
      s2 = nxt(s1);
      step(1'b1, s2, "glitch_relock", 1, 0, 0, g + 1, nxt(s2));
      chk("sat.locked", 32'(s_locked_o), 1);
      chk("sat.err_hold", 32'(s_err_count_o), sat);
      e = nxt(s2);
    end

    step(1'b1, 13, "oor_locked", 0, 0, 1, 6, e);
    chk("sat.oor_count", 32'(s_err_count_o), 3);
    step(1'b1, 3, "hunt_reseed3", 0, 0, 0, 6, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
